// File: rtl/dsp_delay_pkg.sv
// Shared types and constants for the DSP48 delay sequencer and its helpers.
package dsp_delay_pkg;

  // Width of the delay and holdoff values exchanged with the counter.
  localparam int DELAY_W = 16;

  // Depth of the counter's reset-to-C-load pipeline.
  localparam int DEFAULT_SETTLE_CYCLES = 4;
  localparam int DEFAULT_TIMEOUT_BITS  = 18;
  localparam int DEFAULT_MISSED_BITS   = 8;

  typedef logic [DELAY_W-1:0] delay_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RELOAD  = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_COUNT   = 3'd3,
    ST_FIRE    = 3'd4,
    ST_HOLDOFF = 3'd5
  } seq_state_e;

  // The counter only has to be reprogrammed when it holds nothing valid
  // or holds a different target than the one just requested.
  function automatic logic needs_reload(input logic   loaded_valid,
                                        input delay_t req,
                                        input delay_t loaded);
    return !loaded_valid || (req != loaded);
  endfunction

endpackage

// File: rtl/dsp_delay_sequencer_if.sv
// Trigger-side bus of the delay sequencer: request in, delayed trigger and
// status out. The master drives requests, the slave is the sequencer.
interface dsp_delay_sequencer_if #(
  parameter int MISSED_BITS = 8
);
  import dsp_delay_pkg::*;

  logic                   trig_i;
  delay_t                 delay_i;
  delay_t                 holdoff_i;
  logic                   trig_o;
  logic                   busy_o;
  logic                   error_o;
  logic [MISSED_BITS-1:0] missed_count_o;

  modport master (
    output trig_i, delay_i, holdoff_i,
    input  trig_o, busy_o, error_o, missed_count_o
  );

  modport slave (
    input  trig_i, delay_i, holdoff_i,
    output trig_o, busy_o, error_o, missed_count_o
  );

endinterface

// File: rtl/dsp_delay_holdoff_timer.sv
// Loadable down-counter shared by the SETTLE and HOLDOFF waits. done is high
// in the last cycle of the wait, so a load of N gives exactly N cycles.
module dsp_delay_holdoff_timer
  import dsp_delay_pkg::*;
(
  input  logic   fast_clk_i,
  input  logic   fast_rst_i,
  input  logic   load,
  input  delay_t load_value,
  input  logic   dec,
  output logic   done
);

  delay_t count_q;

  // Load takes priority; otherwise count down while enabled, stopping at zero.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and simulation matches the synthesised flops.
  always_ff @(posedge fast_clk_i) begin
    if (fast_rst_i) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (dec && (count_q != '0)) begin
      count_q <= count_q - 1'b1;
    end
  end

  // A zero load also reports done so a wait can never hang.
  assign done = (count_q <= delay_t'(1));

endmodule

// File: rtl/dsp_delay_sequencer.sv
// Trigger-to-delayed-trigger controller in front of the DSP48 pattern-detect
// delay counter. Reloads the counter only when the delay changes, gates its
// enable, fires one delayed pulse, applies a holdoff, and reports missed
// triggers and counter timeouts.
module dsp_delay_sequencer
  import dsp_delay_pkg::*;
#(
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
  parameter int TIMEOUT_BITS  = DEFAULT_TIMEOUT_BITS,
  parameter int MISSED_BITS   = DEFAULT_MISSED_BITS
) (
  input  logic                   fast_clk_i,
  input  logic                   fast_rst_i,
  dsp_delay_sequencer_if.slave   bus,
  output logic                   dly_rst_o,
  output delay_t                 dly_delay_o,
  output logic                   dly_count_enable_o,
  input  logic                   dly_count_reached_i
);

  localparam delay_t SETTLE_LOAD = delay_t'(SETTLE_CYCLES);
  // Watchdog value in the last permitted COUNT cycle (2^TIMEOUT_BITS-1 cycles total).
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  seq_state_e               state_q;
  seq_state_e               state_next;
  logic                     loaded_valid_q;
  delay_t                   dly_delay_q;
  logic                     error_q;
  logic [MISSED_BITS-1:0]   missed_q;
  logic [TIMEOUT_BITS-1:0]  wd_q;

  logic                     take_reload;
  logic                     timeout;
  logic                     timer_load;
  delay_t                   timer_value;
  logic                     timer_dec;
  logic                     timer_done;

  dsp_delay_holdoff_timer u_timer (
    .fast_clk_i (fast_clk_i),
    .fast_rst_i (fast_rst_i),
    .load       (timer_load),
    .load_value (timer_value),
    .dec        (timer_dec),
    .done       (timer_done)
  );

  // State register.
  always_ff @(posedge fast_clk_i) begin
    if (fast_rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_next;
    end
  end

  // Next-state decode and per-state outputs.
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_next         = state_q;
    take_reload        = 1'b0;
    timeout            = 1'b0;
    timer_load         = 1'b0;
    timer_value        = '0;
    timer_dec          = 1'b0;
    dly_rst_o          = 1'b0;
    dly_count_enable_o = 1'b0;
    bus.trig_o         = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.trig_i) begin
          if (bus.delay_i == '0) begin
            // P=0 already matches C=0, so the counter is bypassed.
            state_next = ST_FIRE;
          end else if (needs_reload(loaded_valid_q, bus.delay_i, dly_delay_q)) begin
            take_reload = 1'b1;
            state_next  = ST_RELOAD;
          end else begin
            state_next = ST_COUNT;
          end
        end
      end

      ST_RELOAD: begin
        dly_rst_o = 1'b1;
        if (SETTLE_CYCLES == 0) begin
          state_next = ST_COUNT;
        end else begin
          timer_load  = 1'b1;
          timer_value = SETTLE_LOAD;
          state_next  = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        timer_dec = 1'b1;
        if (timer_done) begin
          state_next = ST_COUNT;
        end
      end

      ST_COUNT: begin
        dly_count_enable_o = 1'b1;
        if (dly_count_reached_i) begin
          state_next = ST_FIRE;
        end else if (wd_q == WD_LAST) begin
          timeout    = 1'b1;
          state_next = ST_IDLE;
        end
      end

      ST_FIRE: begin
        bus.trig_o = 1'b1;
        if (bus.holdoff_i == '0) begin
          state_next = ST_IDLE;
        end else begin
          timer_load  = 1'b1;
          timer_value = bus.holdoff_i;
          state_next  = ST_HOLDOFF;
        end
      end

      ST_HOLDOFF: begin
        timer_dec = 1'b1;
        if (timer_done) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Loaded-delay bookkeeping and the sticky watchdog error.
  always_ff @(posedge fast_clk_i) begin
    if (fast_rst_i) begin
      dly_delay_q    <= '0;
      loaded_valid_q <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      // Captured on entry to RELOAD so it is stable while dly_rst_o is high.
      if (take_reload) begin
        dly_delay_q <= bus.delay_i;
      end
      if (state_q == ST_RELOAD) begin
        loaded_valid_q <= 1'b1;
      end
      // A timed-out counter is in an unknown phase; force the next reload.
      if (timeout) begin
        loaded_valid_q <= 1'b0;
        error_q        <= 1'b1;
      end
    end
  end

  // Watchdog counts consecutive COUNT cycles and restarts on every entry.
  always_ff @(posedge fast_clk_i) begin
    if (fast_rst_i || (state_q != ST_COUNT)) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // Saturating count of triggers that arrive while a sequence is in flight.
  always_ff @(posedge fast_clk_i) begin
    if (fast_rst_i) begin
      missed_q <= '0;
    end else if (bus.trig_i && (state_q != ST_IDLE) && (missed_q != '1)) begin
      missed_q <= missed_q + 1'b1;
    end
  end

  assign dly_delay_o        = dly_delay_q;
  assign bus.busy_o         = (state_q != ST_IDLE);
  assign bus.error_o        = error_q;
  assign bus.missed_count_o = missed_q;

endmodule

// File: tb/tb_dsp_delay_sequencer.sv
// Self-checking bench for dsp_delay_sequencer: directed vector table,
// hand-written corner sequences, and a randomized run against a schedule model.
module tb_dsp_delay_sequencer;
  import dsp_delay_pkg::*;

  localparam int SETTLE = 4;
  localparam int TO_BITS = 6;
  localparam int MB = 8;
  localparam int FAR = 1 << 30;

  logic   fast_clk_i = 1'b0;
  logic   fast_rst_i = 1'b1;
  logic   dly_rst;
  delay_t dly_delay;
  logic   dly_en;
  logic   dly_reached;

  dsp_delay_sequencer_if #(.MISSED_BITS(MB)) bus ();

  dsp_delay_sequencer #(
    .SETTLE_CYCLES (SETTLE),
    .TIMEOUT_BITS  (TO_BITS),
    .MISSED_BITS   (MB)
  ) dut (
    .fast_clk_i          (fast_clk_i),
    .fast_rst_i          (fast_rst_i),
    .bus                 (bus),
    .dly_rst_o           (dly_rst),
    .dly_delay_o         (dly_delay),
    .dly_count_enable_o  (dly_en),
    .dly_count_reached_i (dly_reached)
  );

  always #5 fast_clk_i = ~fast_clk_i;

  // Behavioural counter: reached during the Nth enabled cycle, then wraps.
  int unsigned cnt_m = 0;
  logic        stall = 1'b0;
  always @(posedge fast_clk_i) begin
    if (dly_rst) cnt_m <= 0;
    else if (dly_en) cnt_m <= (cnt_m + 1 == 32'(dly_delay)) ? 0 : cnt_m + 1;
  end
  always_comb dly_reached = !stall && dly_en && (cnt_m + 1 == 32'(dly_delay));

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic longint outs();
    return longint'({bus.busy_o, bus.trig_o, bus.error_o, dly_rst, dly_en,
                     bus.missed_count_o, dly_delay});
  endfunction

  function automatic longint pack_exp(input logic busy, input logic trig, input logic err,
                                      input logic rst, input logic en,
                                      input logic [7:0] missed, input delay_t dly);
    return longint'({busy, trig, err, rst, en, missed, dly});
  endfunction

  task automatic drive(input logic t, input delay_t d, input delay_t h);
    bus.trig_i    = t;
    bus.delay_i   = d;
    bus.holdoff_i = h;
  endtask

  task automatic next();
    @(negedge fast_clk_i);
  endtask

  // Leaves the bench at a negedge in an IDLE cycle whose trigger is accepted.
  task automatic do_reset();
    fast_rst_i = 1'b1;
    drive(1'b0, '0, '0);
    next();
    next();
    fast_rst_i = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget && bus.busy_o; i++) begin
      drive(1'b0, '0, '0);
      next();
    end
    check(name, bus.busy_o, 0);
  endtask

  typedef struct {
    delay_t delay;
    delay_t holdoff;
    int     reload;
    int     en_first;
    int     en_cycles;
    int     fire;
    int     idle;
    delay_t loaded;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx);
    int rst_cnt, rst_first, en_cnt, en_first, trig_cnt, fire, idle;
    rst_cnt = 0; rst_first = -1; en_cnt = 0; en_first = -1;
    trig_cnt = 0; fire = -1; idle = -1;
    drive(1'b1, vecs[idx].delay, vecs[idx].holdoff);
    for (int j = 1; j <= 120; j++) begin
      next();
      drive(1'b0, delay_t'($urandom_range(0, 65535)), vecs[idx].holdoff);
      if (dly_rst) begin rst_cnt++; if (rst_first < 0) rst_first = j; end
      if (dly_en) begin en_cnt++; if (en_first < 0) en_first = j; end
      if (bus.trig_o) begin trig_cnt++; if (fire < 0) fire = j; end
      if (!bus.busy_o) begin idle = j; break; end
    end
    check($sformatf("vec%0d_rst_count", idx), rst_cnt, vecs[idx].reload);
    check($sformatf("vec%0d_rst_cycle", idx), rst_first, vecs[idx].reload ? 1 : -1);
    check($sformatf("vec%0d_en_first", idx), en_first, vecs[idx].en_first);
    check($sformatf("vec%0d_en_cycles", idx), en_cnt, vecs[idx].en_cycles);
    check($sformatf("vec%0d_trig_count", idx), trig_cnt, 1);
    check($sformatf("vec%0d_fire_cycle", idx), fire, vecs[idx].fire);
    check($sformatf("vec%0d_idle_cycle", idx), idle, vecs[idx].idle);
    check($sformatf("vec%0d_dly_delay", idx), dly_delay, vecs[idx].loaded);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int en_cnt, trg_cnt, idle;
    int t_idle, fire_m, rst_m, lo_m, hi_m;
    logic [7:0] missed_m;
    delay_t dly_m, d_now, h_now;
    logic   valid_m, trig_now;

    //                 delay   holdoff rld enF enN fire idle loaded
    vecs[0] = '{16'd10, 16'd0, 1, 6, 10, 16, 17, 16'd10};
    vecs[1] = '{16'd10, 16'd0, 0, 1, 10, 11, 12, 16'd10};
    vecs[2] = '{16'd25, 16'd0, 1, 6, 25, 31, 32, 16'd25};
    vecs[3] = '{16'd0,  16'd0, 0, -1, 0,  1,  2, 16'd25};
    vecs[4] = '{16'd25, 16'd3, 0, 1, 25, 26, 30, 16'd25};
    vecs[5] = '{16'd1,  16'd0, 1, 6, 1,   7,  8, 16'd1};

    drive(1'b0, '0, '0);
    do_reset();
    check("reset_outputs", outs(), 0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Missed triggers during COUNT/HOLDOFF, then acceptance in first IDLE cycle.
    do_reset();
    drive(1'b1, 16'd10, 16'd5);
    for (int j = 1; j <= 22; j++) begin
      next();
      if (j == 16) check("missed_seq_fire", bus.trig_o, 1);
      if (j == 22) check("missed_seq_first_idle", bus.busy_o, 0);
      drive((j == 8) || (j == 12) || (j == 18) || (j == 22), 16'd10, 16'd5);
    end
    next();
    check("rearm_busy", bus.busy_o, 1);
    check("rearm_no_reload", dly_rst, 0);
    check("rearm_count", dly_en, 1);
    check("missed_three", bus.missed_count_o, 3);
    wait_idle("missed_seq_done", 40);

    // Saturation of the missed counter across a long holdoff.
    do_reset();
    trg_cnt = 0;
    drive(1'b1, 16'd0, 16'd400);
    for (int j = 1; j <= 300; j++) begin
      next();
      if (bus.trig_o) trg_cnt++;
      drive(1'b1, delay_t'($urandom_range(0, 40)), 16'd400);
    end
    next();
    check("missed_saturated", bus.missed_count_o, 255);
    check("saturate_single_trig", trg_cnt, 1);
    wait_idle("saturate_done", 200);

    // Watchdog timeout with a counter that never reaches.
    do_reset();
    stall = 1'b1;
    en_cnt = 0; trg_cnt = 0; idle = -1;
    drive(1'b1, 16'd7, 16'd0);
    for (int j = 1; j <= 150; j++) begin
      next();
      drive(1'b0, 16'd7, 16'd0);
      if (dly_en) en_cnt++;
      if (bus.trig_o) trg_cnt++;
      if (!bus.busy_o) begin idle = j; break; end
    end
    check("timeout_idle_cycle", idle, 69);
    check("timeout_en_cycles", en_cnt, 63);
    check("timeout_no_trig", trg_cnt, 0);
    check("timeout_error", bus.error_o, 1);
    stall = 1'b0;
    drive(1'b1, 16'd7, 16'd0);
    next();
    check("timeout_forces_reload", dly_rst, 1);
    wait_idle("timeout_recover_done", 40);
    check("error_sticky", bus.error_o, 1);

    // Reset in the middle of COUNT.
    do_reset();
    drive(1'b1, 16'd20, 16'd0);
    for (int j = 1; j <= 10; j++) begin
      next();
      drive(1'b0, 16'd20, 16'd0);
    end
    check("midcount_enabled", dly_en, 1);
    fast_rst_i = 1'b1;
    next();
    fast_rst_i = 1'b0;
    check("midcount_reset_outputs", outs(), 0);
    drive(1'b1, 16'd20, 16'd0);
    next();
    check("post_reset_reload", dly_rst, 1);
    check("post_reset_delay", dly_delay, 20);
    wait_idle("post_reset_done", 60);

    // Randomized run against a schedule model derived from the timing rules.
    do_reset();
    t_idle = 0; fire_m = -1; rst_m = -1; lo_m = -1; hi_m = -2;
    missed_m = '0; dly_m = '0; valid_m = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      check($sformatf("rand_cycle%0d", k), outs(),
            pack_exp(k < t_idle, k == fire_m, 1'b0, k == rst_m,
                     (k >= lo_m) && (k <= hi_m), missed_m, dly_m));
      h_now = delay_t'($urandom_range(0, 6));
      case ($urandom_range(0, 7))
        0:       d_now = '0;
        1, 2, 3: d_now = dly_m;
        default: d_now = delay_t'($urandom_range(1, 20));
      endcase
      trig_now = ($urandom_range(0, 3) == 0);
      drive(trig_now, d_now, h_now);
      if (k == fire_m) t_idle = k + 1 + int'(h_now);
      if (trig_now) begin
        if (k >= t_idle) begin
          t_idle = FAR;
          rst_m = -1; lo_m = -1; hi_m = -2;
          if (d_now == '0) begin
            fire_m = k + 1;
          end else begin
            if (!valid_m || d_now != dly_m) begin
              rst_m = k + 1; dly_m = d_now; valid_m = 1'b1;
              lo_m = k + 2 + SETTLE;
            end else begin
              lo_m = k + 1;
            end
            hi_m = lo_m + int'(d_now) - 1;
            fire_m = lo_m + int'(d_now);
          end
        end else if (missed_m != 8'hFF) begin
          missed_m = missed_m + 8'd1;
        end
      end
      next();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
